// File: rtl/freq_meter_ctrl_pkg.sv
// freq_meter_pkg: shared types and defaults for the gated edge-count
// frequency meter (freq_meter_ctrl and its edge_count_unit).
// Optional build macro used by the other files: FREQ_METER_SAT_EN.

package freq_meter_pkg;

  // Default widths of the edge counter/result and the window down-counter.
  localparam int COUNT_W_DEF = 32;
  localparam int WIN_W_DEF   = 32;

  // Controller states; encodings are fixed so debug views stay stable.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } fm_state_e;

  // True in every state that belongs to an accepted measurement.
  function automatic logic fm_is_busy(input fm_state_e st);
    return (st != ST_IDLE);
  endfunction

  // True in the single cycle that publishes a finished measurement.
  function automatic logic fm_is_done(input fm_state_e st);
    return (st == ST_DONE);
  endfunction

endpackage : freq_meter_pkg

// File: rtl/freq_meter_ctrl_if.sv
// freq_meter_ctrl_if: request/result bundle of the frequency meter.
// The master side issues start/abort/window_len, the slave side (the
// meter) returns busy/done and the captured result.
// With FREQ_METER_SAT_EN defined the bundle also carries the captured
// overflow flag of the saturating counter.

interface freq_meter_ctrl_if
  import freq_meter_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int WIN_W   = WIN_W_DEF
);

  logic               start;
  logic               abort;
  logic [WIN_W-1:0]   window_len;
  logic               busy;
  logic               done;
  logic               count_valid;
  logic [COUNT_W-1:0] count_out;
`ifdef FREQ_METER_SAT_EN
  logic               overflow;
`endif

`ifdef FREQ_METER_SAT_EN
  modport master (
    output start, abort, window_len,
    input  busy, done, count_valid, count_out, overflow
  );

  modport slave (
    input  start, abort, window_len,
    output busy, done, count_valid, count_out, overflow
  );
`else
  modport master (
    output start, abort, window_len,
    input  busy, done, count_valid, count_out
  );

  modport slave (
    input  start, abort, window_len,
    output busy, done, count_valid, count_out
  );
`endif

endinterface : freq_meter_ctrl_if

// File: rtl/freq_meter_ctrl_edge_count_unit.sv
// edge_count_unit: samples the measured signal, detects rising edges and
// counts them while enabled. clear_i has priority over counting.
// Without FREQ_METER_SAT_EN the counter wraps modulo 2^COUNT_W; with
// FREQ_METER_SAT_EN it sticks at the all-ones value and raises
// overflow_o when a further increment is attempted.

module edge_count_unit
  import freq_meter_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sig_i,
  input  logic               clear_i,
  input  logic               en_i,
`ifdef FREQ_METER_SAT_EN
  output logic               overflow_o,
`endif
  output logic [COUNT_W-1:0] count_o
);

  logic               sig_q;
  logic               rise_s;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
`ifdef FREQ_METER_SAT_EN
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  logic               ovf_q;
  logic               ovf_d;
`endif

  // Rising edge: high now, low in the previous cycle.
  assign rise_s = sig_i & ~sig_q;

  // Next counter value: clear first, otherwise count qualified edges.
  always_comb begin
    cnt_d = cnt_q;
`ifdef FREQ_METER_SAT_EN
    ovf_d = ovf_q;
`endif
    if (clear_i) begin
      cnt_d = {COUNT_W{1'b0}};
`ifdef FREQ_METER_SAT_EN
      ovf_d = 1'b0;
`endif
    end else if (en_i && rise_s) begin
`ifdef FREQ_METER_SAT_EN
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
`else
      cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
`endif
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sample the input every cycle and update the counter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
      cnt_q <= {COUNT_W{1'b0}};
`ifdef FREQ_METER_SAT_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      sig_q <= sig_i;
      cnt_q <= cnt_d;
`ifdef FREQ_METER_SAT_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign count_o = cnt_q;
`ifdef FREQ_METER_SAT_EN
  assign overflow_o = ovf_q;
`endif

endmodule : edge_count_unit

// File: rtl/freq_meter_ctrl.sv
// freq_meter_ctrl: gated edge-count measurement controller.
// A start in IDLE latches window_len, one CLEAR cycle zeroes the edge
// counter, MEASURE counts rising edges of sig_i for window_len cycles,
// and DONE captures the count into count_out and raises count_valid.
// abort leaves CLEAR/MEASURE without a result; rst_i overrides all.
// Build macro: FREQ_METER_SAT_EN (saturating counter plus overflow flag).
// All outputs come from registers or the registered state.

module freq_meter_ctrl
  import freq_meter_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int WIN_W   = WIN_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sig_i,
  freq_meter_ctrl_if.slave     bus
);

  fm_state_e          state_q;
  fm_state_e          state_d;
  logic [WIN_W-1:0]   win_rem_q;
  logic [WIN_W-1:0]   win_rem_d;
  logic               count_valid_q;
  logic               count_valid_d;
  logic [COUNT_W-1:0] count_out_q;
  logic [COUNT_W-1:0] count_out_d;
  logic [COUNT_W-1:0] edge_cnt_s;
  logic               cnt_clear_s;
  logic               cnt_en_s;
`ifdef FREQ_METER_SAT_EN
  logic               overflow_q;
  logic               overflow_d;
  logic               edge_ovf_s;
`endif

  // The counter is zeroed in CLEAR even when that cycle is aborted, and
  // an edge in an aborted MEASURE cycle is not counted.
  assign cnt_clear_s = (state_q == ST_CLEAR);
  assign cnt_en_s    = (state_q == ST_MEASURE) && !bus.abort;

  edge_count_unit #(
    .COUNT_W (COUNT_W)
  ) u_edge_count (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sig_i      (sig_i),
    .clear_i    (cnt_clear_s),
    .en_i       (cnt_en_s),
`ifdef FREQ_METER_SAT_EN
    .overflow_o (edge_ovf_s),
`endif
    .count_o    (edge_cnt_s)
  );

  // Next state, window countdown and result capture.
  always_comb begin
    state_d       = state_q;
    win_rem_d     = win_rem_q;
    count_valid_d = count_valid_q;
    count_out_d   = count_out_q;
`ifdef FREQ_METER_SAT_EN
    overflow_d    = overflow_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // abort is meaningless here; start alone decides.
        if (bus.start) begin
          state_d   = ST_CLEAR;
          win_rem_d = bus.window_len;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        count_valid_d = 1'b0;
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (win_rem_q == {WIN_W{1'b0}}) begin
          // Zero-length window: report an empty count straight away.
          state_d = ST_DONE;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          win_rem_d = win_rem_q - {{(WIN_W-1){1'b0}}, 1'b1};
          // Leaving on the last window cycle still counts its edge.
          if (win_rem_q == {{(WIN_W-1){1'b0}}, 1'b1}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MEASURE;
          end
        end
      end
      ST_DONE: begin
        count_out_d   = edge_cnt_s;
        count_valid_d = 1'b1;
`ifdef FREQ_METER_SAT_EN
        overflow_d    = edge_ovf_s;
`endif
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      win_rem_q     <= {WIN_W{1'b0}};
      count_valid_q <= 1'b0;
      count_out_q   <= {COUNT_W{1'b0}};
`ifdef FREQ_METER_SAT_EN
      overflow_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      win_rem_q     <= win_rem_d;
      count_valid_q <= count_valid_d;
      count_out_q   <= count_out_d;
`ifdef FREQ_METER_SAT_EN
      overflow_q    <= overflow_d;
`endif
    end
  end

  assign bus.busy        = fm_is_busy(state_q);
  assign bus.done        = fm_is_done(state_q);
  assign bus.count_valid = count_valid_q;
  assign bus.count_out   = count_out_q;
`ifdef FREQ_METER_SAT_EN
  assign bus.overflow    = overflow_q;
`endif

endmodule : freq_meter_ctrl

// File: tb/tb_freq_meter_ctrl.sv
// tb_freq_meter_ctrl: directed bench for freq_meter_ctrl.
// Two instances share all stimulus: dut_a with 32-bit counter and dut_b
// with a 4-bit counter for the wrap/saturation case.
// Cycle labels: the cycle following the edge that samples start is
// CLEAR (c=0); MEASURE is c=1..N; DONE is c=N+1, i.e. N+2 cycles after
// the start cycle.

module tb_freq_meter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        sig;
  logic [31:0] window_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  freq_meter_ctrl_if #(.COUNT_W(32), .WIN_W(32)) bus_a ();
  freq_meter_ctrl_if #(.COUNT_W(4),  .WIN_W(32)) bus_b ();

  assign bus_a.start      = start;
  assign bus_a.abort      = abort;
  assign bus_a.window_len = window_len;
  assign bus_b.start      = start;
  assign bus_b.abort      = abort;
  assign bus_b.window_len = window_len;

  freq_meter_ctrl #(.COUNT_W(32), .WIN_W(32)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .sig_i (sig),
    .bus   (bus_a)
  );

  freq_meter_ctrl #(.COUNT_W(4), .WIN_W(32)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .sig_i (sig),
    .bus   (bus_b)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // sig value driven for cycle c (c=0 is CLEAR).
  // 0: low, 1: high, 2: toggle (0 at CLEAR), 3: period 4 as 0,0,1,1.
  function automatic logic sig_fn(input int pat, input int c);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((c % 2) == 1);
      3:       return ((c % 4) >= 2);
      default: return 1'b0;
    endcase
  endfunction

  // One measurement from the IDLE state; bounded to n+8 cycles past CLEAR.
  task automatic run_meas(input int n, input int pat, input int abort_at,
                          input int busy_start_at, output int lat, output int n_done);
    lat    = 0;
    n_done = 0;
    start      = 1'b1;
    window_len = n;
    sig        = (pat == 1);
    abort      = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    sig   = sig_fn(pat, 0);
    for (int k = 1; k <= n + 8; k++) begin
      @(posedge clk); #1;
      if (bus_a.done) begin
        n_done++;
        if (lat == 0) lat = k + 1;
      end
      if (abort_at > 0 && k == abort_at + 1) chk("abort_to_idle", bus_a.busy, 0);
      sig   = sig_fn(pat, k);
      abort = (k == abort_at);
      start = (k == busy_start_at);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  int lat;
  int nd;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    sig        = 1'b0;
    window_len = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  bus_a.busy, 0);
    chk("rst_done",  bus_a.done, 0);
    chk("rst_valid", bus_a.count_valid, 0);
    chk("rst_count", bus_a.count_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Toggle, N=100: 50 rises; a start pulse while busy is ignored.
    run_meas(100, 2, 0, 30, lat, nd);
    chk("tog_latency", lat, 102);
    chk("tog_done_cnt", nd, 1);
    chk("tog_count", bus_a.count_out, 50);
    chk("tog_valid", bus_a.count_valid, 1);
    chk("tog_idle", bus_a.busy, 0);
`ifdef FREQ_METER_SAT_EN
    chk("tog_ovf_a", bus_a.overflow, 0);
`endif

    // Held high / held low, N=20: no rising edges inside the window.
    run_meas(20, 1, 0, 0, lat, nd);
    chk("high_latency", lat, 22);
    chk("high_count", bus_a.count_out, 0);
    chk("high_valid", bus_a.count_valid, 1);
    run_meas(20, 0, 0, 0, lat, nd);
    chk("low_count", bus_a.count_out, 0);
    chk("low_done_cnt", nd, 1);

    // Zero-length window: DONE two cycles after start.
    run_meas(0, 2, 0, 0, lat, nd);
    chk("zero_latency", lat, 2);
    chk("zero_count", bus_a.count_out, 0);
    chk("zero_valid", bus_a.count_valid, 1);

    // Abort in MEASURE cycle 10 of 100.
    run_meas(100, 2, 10, 0, lat, nd);
    chk("abort_done_cnt", nd, 0);
    chk("abort_valid", bus_a.count_valid, 0);

    // Period 4 (0,0,1,1), N=10: rises at c=2,6,10.
    run_meas(10, 3, 0, 0, lat, nd);
    chk("p4_latency", lat, 12);
    chk("p4_count", bus_a.count_out, 3);
    chk("p4_valid", bus_a.count_valid, 1);

    // Toggle, N=64: 32 rises; 4-bit counter wraps or saturates.
    run_meas(64, 2, 0, 0, lat, nd);
    chk("w64_count_a", bus_a.count_out, 32);
    chk("w64_valid_b", bus_b.count_valid, 1);
`ifdef FREQ_METER_SAT_EN
    chk("w64_count_b_sat", bus_b.count_out, 15);
    chk("w64_ovf_b", bus_b.overflow, 1);
    chk("w64_ovf_a", bus_a.overflow, 0);
`else
    chk("w64_count_b_wrap", bus_b.count_out, 0);
`endif

    // Reset in the middle of MEASURE.
    start      = 1'b1;
    window_len = 32'd50;
    sig        = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sig = sig_fn(2, k);
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", bus_a.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy",  bus_a.busy, 0);
    chk("mid_rst_done",  bus_a.done, 0);
    chk("mid_rst_valid", bus_a.count_valid, 0);
    chk("mid_rst_count", bus_a.count_out, 0);
    chk("mid_rst_count_b", bus_b.count_out, 0);
    rst = 1'b0;
    nd  = 0;
    for (int k = 0; k < 60; k++) begin
      sig = sig_fn(2, k);
      @(posedge clk); #1;
      if (bus_a.done) nd++;
    end
    chk("post_rst_done_cnt", nd, 0);
    chk("post_rst_valid", bus_a.count_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_freq_meter_ctrl

// File: doc/freq_meter_ctrl.md
Name: freq_meter_ctrl

Overview:
- Gated edge-count measurement controller for PLL simulation/verification.
- On a start request it clears an internal edge counter and opens a counting window of a programmable number of clk cycles.
- It counts rising edges of a sampled input `sig`, then captures the result and signals completion with a done/valid handshake.
- Used to measure PLL output frequency or duty ratio against the reference clock: edges per window give frequency.

Parameters:
- COUNT_W, 32, width of edge counter and result.
- WIN_W, 32, width of window-length input and internal window down-counter.

Ports:
- clk  input  1  system/reference clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request measurement; sampled only in IDLE.
- abort  input  1  cancel measurement in CLEAR/MEASURE.
- window_len  input  WIN_W  window length in clk cycles; latched when start is accepted.
- sig  input  1  signal under measurement, already synchronous to clk.
- busy  output  1  high in CLEAR, MEASURE, DONE.
- done  output  1  high for exactly one cycle (state DONE).
- count_valid  output  1  count_out holds a completed result.
- count_out  output  COUNT_W  captured edge count.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; busy=0, done=0, count_valid=0, count_out=0.
  - Internal counter=0, window counter=0, sig_q=0.
  - Reset overrides all other inputs, including mid-measurement: no done pulse and no capture.
- All outputs are registered or decoded from the registered state (Moore); there are no combinational input-to-output paths.
- Edge detect: sig_q <= sig every cycle in all states; rise = sig & ~sig_q.
- FSM states: IDLE, CLEAR, MEASURE, DONE.
- IDLE:
  - start=1 -> CLEAR; latch window_len into win_rem.
  - start=0 -> stay.
  - abort is ignored.
- CLEAR (1 cycle):
  - edge counter <= 0; count_valid <= 0.
  - If win_rem==0 -> DONE (captures 0); else -> MEASURE.
  - abort=1 -> IDLE (count_valid stays 0).
- MEASURE:
  - Each cycle: if rise, counter <= counter+1 (mod 2^COUNT_W); win_rem <= win_rem-1.
  - When win_rem==1 in this cycle -> DONE. MEASURE therefore lasts exactly window_len cycles, and an edge detected in the last cycle is counted.
  - abort=1 -> IDLE; the edge in that cycle is not counted and count_valid stays 0.
- DONE (1 cycle):
  - count_out <= counter (value including the last MEASURE cycle); count_valid <= 1; -> IDLE.
- Latency: start sampled at edge t -> CLEAR at t+1, MEASURE t+2..t+1+N, DONE at t+2+N. done is high during DONE; count_out/count_valid update at the edge leaving DONE.
- count_valid and count_out hold until the next accepted start (count_valid is cleared in CLEAR) or reset.
- start while busy is ignored (no queuing). start and abort together in IDLE: start wins.
- Simultaneous abort and last MEASURE cycle: abort wins, no DONE.

Optional Feature:
- Macro: FREQ_METER_SAT_EN.
- Defined:
  - Edge counter saturates at 2^COUNT_W-1.
  - Extra output port `overflow` (1 bit): set when an increment is attempted at max value; cleared in CLEAR and reset; captured alongside count_out in DONE.
- Undefined: counter wraps modulo 2^COUNT_W; no overflow port.

Decomposition:
- Package freq_meter_pkg:
  - State enum/localparams (IDLE=2'd0, CLEAR=2'd1, MEASURE=2'd2, DONE=2'd3).
  - Default COUNT_W/WIN_W constants.
- Sub-module edge_count_unit: sig_q register, rise detect, and clear/enable counter, including the saturation/overflow logic under the macro. The FSM lives in the top module.

Test Plan:
- sig toggles every clk cycle (0 at CLEAR), window_len=100, start pulse -> done exactly 102 cycles after start sampled; count_out=50; count_valid=1.
- sig held high throughout, window_len=20 -> count_out=0; held low -> 0.
- window_len=0 -> DONE two cycles after start; count_out=0; count_valid=1.
- Abort during MEASURE (cycle 10 of 100) -> IDLE next cycle; done never asserted; count_valid=0.
  - Then start with window_len=10, sig period 4 -> result valid, count_out 2 or 3 by phase (checked exactly against the model).
- COUNT_W=4, sig period 2, window_len=64 (32 edges):
  - Without macro -> count_out=0.
  - With FREQ_METER_SAT_EN -> count_out=15, overflow=1.
- rst asserted mid-MEASURE -> all outputs 0 at next edge; start pulses while busy are ignored (done pulses exactly once per accepted start).
